// File: rtl/mux_sel_ctrl.sv
// Select-line controller for a downstream 2:1 mux: a debounced pushbutton toggles the
// select, an optional auto-scan toggles it periodically, and every change emits a one-cycle pulse.
module mux_sel_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] SCAN_PERIOD     = 24'd5000000,
    parameter logic        SEL_INIT        = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic auto_en,
    output logic sel,
    output logic sel_changed,
    output logic btn_clean
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] ARM_PRESS   = 2'd1;
    localparam logic [1:0] PRESSED     = 2'd2;
    localparam logic [1:0] ARM_RELEASE = 2'd3;

    logic        btn_s1_q, btn_s2_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        clean_q, clean_d;
    logic        press_q, press_d;
    logic [23:0] scan_q, scan_d;
    logic        sel_q, sel_d;
    logic        chg_q, chg_d;
    logic        scan_tick;
    logic        toggle;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        press_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s2_q) begin
                    state_d = ARM_PRESS;
                    cnt_d   = 16'd1;
                end
            end
            ARM_PRESS: begin
                if (!btn_s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                    state_d = PRESSED;
                    clean_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PRESSED: begin
                if (!btn_s2_q) begin
                    state_d = ARM_RELEASE;
                    cnt_d   = 16'd1;
                end
            end
            default: begin
                if (btn_s2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                    state_d = IDLE;
                    clean_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
    end

    // A press restarts the scan period, so a coincident tick still yields a single toggle.
    always_comb begin
        scan_tick = auto_en && (scan_q == SCAN_PERIOD - 24'd1);
        toggle    = press_q | scan_tick;
        scan_d    = (!auto_en || press_q || scan_tick) ? '0 : scan_q + 24'd1;
        sel_d     = sel_q ^ toggle;
        chg_d     = toggle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            clean_q  <= 1'b0;
            press_q  <= 1'b0;
            scan_q   <= '0;
            sel_q    <= SEL_INIT;
            chg_q    <= 1'b0;
        end else begin
            btn_s1_q <= btn_raw;
            btn_s2_q <= btn_s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            press_q  <= press_d;
            scan_q   <= scan_d;
            sel_q    <= sel_d;
            chg_q    <= chg_d;
        end
    end

    assign sel         = sel_q;
    assign sel_changed = chg_q;
    assign btn_clean   = clean_q;

endmodule

// File: doc/mux_sel_ctrl.md
Name: mux_sel_ctrl

Overview:
- Drives the select line of the 2-to-1 multiplexor stage that sits directly downstream.
- Takes a raw, bouncing pushbutton and debounces it; each clean press toggles the select.
- An optional auto-scan mode alternates the select periodically.
- Emits a one-cycle pulse on every select change, for LEDs and downstream logging.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: number of consecutive stable synchronized samples required to accept a button level change. Legal range 2..65535.
- SCAN_PERIOD, 24'd5000000: clock cycles between automatic toggles when auto_en=1. Legal range 2..2^24-1.
- SEL_INIT, 1'b0: select value loaded at reset.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- btn_raw, input, 1: raw pushbutton, asynchronous to clk, active-high, bouncing.
- auto_en, input, 1: synchronous level; 1 enables periodic auto-toggle.
- sel, output, 1: registered select to the mux stage.
- sel_changed, output, 1: one-cycle pulse in the cycle sel takes its new value.
- btn_clean, output, 1: debounced button level, for debug.

Behaviour:
- Reset (rst_n=0, asynchronous assert): all registers clear immediately.
  - sel=SEL_INIT, sel_changed=0, btn_clean=0.
  - Synchronizer flops=0, debounce counter=0, scan counter=0, FSM=IDLE.
  - Release is sampled on clk; the first active edge follows.
- Synchronizer: two flops on btn_raw (btn_s1 -> btn_s2). Only btn_s2 is used downstream.
- Debounce FSM, 16-bit counter cnt:
  - IDLE (btn_clean=0): if btn_s2=1, go to ARM_PRESS with cnt=1; else hold.
  - ARM_PRESS: if btn_s2=0, return to IDLE with cnt=0.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED, set btn_clean=1, assert the press event for 1 cycle.
    - Else cnt++.
  - PRESSED (btn_clean=1): if btn_s2=0, go to ARM_RELEASE with cnt=1; else hold.
  - ARM_RELEASE: if btn_s2=1, return to PRESSED with cnt=0.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE and set btn_clean=0. No event on release.
- Timing: the press event occurs exactly DEBOUNCE_CYCLES cycles after btn_s2 first reads 1, given a stable high. From a btn_raw edge this is DEBOUNCE_CYCLES+2 cycles.
- Scan counter, 24-bit, active only when auto_en=1:
  - Increments every cycle; at SCAN_PERIOD-1 it wraps to 0 and asserts the scan tick for 1 cycle.
  - When auto_en=0 it is held at 0 and no ticks occur.
  - auto_en 0->1 therefore starts a full period.
- Toggle rule: if the press event or the scan tick is asserted in cycle N:
  - sel inverts at the edge ending cycle N.
  - sel_changed=1 during cycle N+1 only.
- Simultaneous press event and scan tick: exactly one toggle. The scan counter resets to 0.
- Any press event also resets the scan counter to 0, so the user press restarts the scan period.
- Consecutive events are allowed; toggles back-to-back produce sel_changed high on consecutive cycles.
- Reset mid-debounce or mid-scan: all progress is discarded. A held button after reset needs a full DEBOUNCE_CYCLES to register.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4, SCAN_PERIOD=10, SEL_INIT=0):
- Reset: hold rst_n=0 for 3 cycles, assert mid-cycle -> sel=0, sel_changed=0, btn_clean=0 immediately; they stay so for 20 cycles with btn_raw=0 and auto_en=0.
- Clean press: btn_raw=1 held for 12 cycles -> btn_clean rises 6 cycles after the btn_raw edge; sel 0->1; a single sel_changed pulse. Release (held 0) -> btn_clean falls after 6 cycles; sel stays 1.
- Bounce rejection: btn_raw pattern 1,1,1,0,1,1,0,1 then 0 -> no toggle, btn_clean stays 0. Next 1 held 8 cycles -> exactly one toggle.
- Auto scan: auto_en=1 for 35 cycles -> sel toggles at cycles 10, 20, 30 after enable, each with one sel_changed pulse. Drop auto_en -> no further toggles.
- Collision: debounced press aligned to the cycle of a scan tick -> exactly one toggle. The next scan toggle comes 10 cycles later.
- Reset mid-operation: pull rst_n low in ARM_PRESS (cnt=2) with auto_en=1 -> sel returns to 0 asynchronously. After release with the button still held, the toggle needs a full 4 stable synchronized cycles.
